prime_power_sequencer: RTL
==========================

// Module: prime_power_sequencer
// PURPOSE
//  Sequences exponent_finder over every prime p <= a run-time bound B for Pollard's p-1 stage 1.
//  On each prime it presets the finder, waits for it, captures the exponent and hands the (p, e)
//  pair downstream over a valid/ready stream to the modular-exponentiation unit.
//  Also guards the finder with a watchdog, since its 8-bit product register can wrap and never finish.
// PARAMETERS
//  NUM_PRIMES  54   entries in the prime table (all primes < 256, ascending)
//  MAX_WAIT    12   cycles allowed in RUN for ef_ready before the run aborts with error
//  IDX_W       6    prime-index / pair-count width, >= clog2(NUM_PRIMES+1)
// PORTS
//  clk          in   1  rising-edge clock
//  rst          in   1  asynchronous, active-high reset
//  start        in   1  one-cycle request; sampled only in IDLE
//  boundary     in   8  bound B; latched on accepted start
//  busy         out  1  high in every state except IDLE
//  done         out  1  one-cycle pulse on normal completion
//  error        out  1  sticky watchdog flag; cleared by the next accepted start or by rst
//  pair_count   out  6  number of pairs emitted in the current/last run
//  ef_enable    out  1  exponent_finder input_enable
//  ef_base      out  9  exponent_finder base (current prime, zero-extended)
//  ef_boundary  out  8  exponent_finder boundary (latched B)
//  ef_exponent  in   8  exponent_finder exponent
//  ef_ready     in   1  exponent_finder ready
//  pp_valid     out  1  pair valid
//  pp_ready     in   1  downstream accept
//  pp_base      out  9  prime of the pair
//  pp_exponent  out  8  exponent of the pair
//  pp_last      out  1  marks the final pair of the run
// BEHAVIOUR
//  Reset: state=IDLE. busy, done, error, ef_enable, pp_valid and pp_last are 0.
//   pair_count, idx, ef_base, pp_base and pp_exponent are 0. b_lat = 0.
//  IDLE: on start, latch b_lat=boundary, idx=0, pair_count=0, clear error.
//   If b_lat<2 -> DONE (no pairs emitted); else -> CLEAR.
//  CLEAR (1 cycle): ef_enable=0; ef_base=prime[idx]. The finder clears to exponent 0 / product 1 on this edge. -> RUN.
//  RUN: ef_enable=1, wdog counts from 0.
//   ef_ready=1 -> capture pp_base=prime[idx], pp_exponent=ef_exponent; drop ef_enable; -> EMIT.
//   ef_ready=0 and wdog==MAX_WAIT-1 -> error=1, ef_enable=0 -> IDLE (no pp_valid, no done).
//  EMIT: pp_valid=1. pp_base, pp_exponent and pp_last are held stable until pp_ready. ef_enable=0 throughout.
//   pp_last = (idx==NUM_PRIMES-1) || (prime[idx+1] > b_lat).
//   On pp_valid&&pp_ready: pair_count++; if pp_last -> DONE else idx++ -> CLEAR.
//  DONE: done=1 for exactly one cycle, busy=0 from the next cycle -> IDLE.
//  start outside IDLE is ignored (no queueing); boundary changes after latch have no effect.
//  pp_ready while pp_valid=0 is ignored. pp_valid never drops without a handshake except on rst.
//  rst mid-run: asynchronously returns to reset values, including ef_enable=0 and pp_valid=0. Any in-flight pair is lost.
//  Per-pair cost with pp_ready held high: 1 (CLEAR) + RUN cycles (ef_ready latency) + 1 (EMIT).
//  No arithmetic beyond compares. Primes are 8-bit values zero-extended to 9 bits on ef_base/pp_base.
// STRUCTURE
//  Package pollard_pkg:
//   - PRIME_TABLE (54 x 8-bit constant array, 2..251) and NUM_PRIMES.
//   - Widths BASE_W=9, EXP_W=8, BOUND_W=8.
//   - State enum {IDLE, CLEAR, RUN, EMIT, DONE}.
//  One sub-module: prime_rom (combinational, idx -> prime, plus next-prime lookup for pp_last).
//  All else is the FSM, watchdog counter and output registers in this module.
// TESTING  (bench instantiates the real exponent_finder)
//  1. B=10, pp_ready=1: pairs (2,4),(3,3),(5,2),(7,2); pp_last only on (7,2); done pulse; pair_count=4.
//  2. B=1, start: no pp_valid; done pulses 2 cycles after start; pair_count=0; error=0.
//  3. B=255: p=2 product wraps (128*2 -> 0) -> error=1 after MAX_WAIT RUN cycles; no pair emitted; busy drops; no done.
//  4. B=10, pp_ready low 5 cycles on first pair: pp_valid stays 1 with (2,4) stable, ef_enable=0; accept on cycle 6.
//  5. rst asserted in RUN for p=3 (B=10): outputs return to reset values without a clock edge.
//     Then start with B=3 gives (2,2),(3,1) with last on (3,1).
//  6. start re-pulsed while busy (B=10, second boundary=5): ignored; run still emits the four B=10 pairs.

Source files
------------

// File: rtl/pollard_pkg.sv
// Shared constants, widths and state encoding for the Pollard p-1 stage-1 prime sequencer.
package pollard_pkg;

    localparam int NUM_PRIMES = 54;
    localparam int BASE_W     = 9;
    localparam int EXP_W      = 8;
    localparam int BOUND_W    = 8;

    // Every prime below 256, ascending.
    localparam logic [7:0] PRIME_TABLE [NUM_PRIMES] = '{
        8'd2,   8'd3,   8'd5,   8'd7,   8'd11,  8'd13,  8'd17,  8'd19,  8'd23,  8'd29,
        8'd31,  8'd37,  8'd41,  8'd43,  8'd47,  8'd53,  8'd59,  8'd61,  8'd67,  8'd71,
        8'd73,  8'd79,  8'd83,  8'd89,  8'd97,  8'd101, 8'd103, 8'd107, 8'd109, 8'd113,
        8'd127, 8'd131, 8'd137, 8'd139, 8'd149, 8'd151, 8'd157, 8'd163, 8'd167, 8'd173,
        8'd179, 8'd181, 8'd191, 8'd193, 8'd197, 8'd199, 8'd211, 8'd223, 8'd227, 8'd229,
        8'd233, 8'd239, 8'd241, 8'd251
    };

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/prime_rom.sv
// Combinational prime lookup: the prime at idx, the one after it, and whether idx is the last entry.
module prime_rom
    import pollard_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       prime,
    output logic [7:0]       next_prime,
    output logic             is_final
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [7:0]       rom [DEPTH];
    logic [IDX_W-1:0] idx_next;

    // Unused slots read as 255 so a stray next-prime compare never looks smaller than the bound.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_rom
            if (gi < NUM_PRIMES) begin : g_used
                assign rom[gi] = PRIME_TABLE[gi];
            end else begin : g_pad
                assign rom[gi] = 8'hFF;
            end
        end
    endgenerate

    assign idx_next   = idx + IDX_W'(1);
    assign prime      = rom[idx];
    assign next_prime = rom[idx_next];
    assign is_final   = (idx == IDX_W'(NUM_PRIMES - 1));

endmodule

// File: rtl/prime_power_sequencer.sv
// Walks every prime p <= B through exponent_finder and streams the resulting (p, e) pairs,
// aborting with a sticky error if the finder stalls past the watchdog limit.
module prime_power_sequencer
    import pollard_pkg::*;
#(
    parameter int MAX_WAIT = 12,
    parameter int IDX_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BOUND_W-1:0] boundary,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [IDX_W-1:0]   pair_count,
    output logic               ef_enable,
    output logic [BASE_W-1:0]  ef_base,
    output logic [BOUND_W-1:0] ef_boundary,
    input  logic [EXP_W-1:0]   ef_exponent,
    input  logic               ef_ready,
    output logic               pp_valid,
    input  logic               pp_ready,
    output logic [BASE_W-1:0]  pp_base,
    output logic [EXP_W-1:0]   pp_exponent,
    output logic               pp_last
);

    localparam int WDOG_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [BOUND_W-1:0] b_lat_reg;
    logic [IDX_W-1:0]   pair_count_reg;
    logic [BASE_W-1:0]  ef_base_reg;
    logic [BASE_W-1:0]  pp_base_reg;
    logic [EXP_W-1:0]   pp_exponent_reg;
    logic               error_reg;
    logic [WDOG_W-1:0]  wdog_reg;

    logic [7:0]         prime_cur;
    logic [7:0]         prime_next;
    logic               idx_final;
    logic               last_pair;
    logic               wdog_expired;

    prime_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .idx        (idx_reg),
        .prime      (prime_cur),
        .next_prime (prime_next),
        .is_final   (idx_final)
    );

    assign last_pair    = idx_final || (prime_next > b_lat_reg);
    assign wdog_expired = (wdog_reg == WDOG_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (boundary < BOUND_W'(2)) ? DONE : CLEAR;
                end
            end
            CLEAR: state_next = RUN;
            RUN: begin
                if (ef_ready) begin
                    state_next = EMIT;
                end else if (wdog_expired) begin
                    state_next = IDLE;
                end
            end
            EMIT: begin
                if (pp_ready) begin
                    state_next = last_pair ? DONE : CLEAR;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != IDLE);
        done      = (state_reg == DONE);
        ef_enable = (state_reg == RUN);
        pp_valid  = (state_reg == EMIT);
        pp_last   = (state_reg == EMIT) && last_pair;
    end

    // ef_base is loaded on the way into CLEAR so the finder sees the new prime for the whole clear cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg         <= '0;
            b_lat_reg       <= '0;
            pair_count_reg  <= '0;
            ef_base_reg     <= '0;
            pp_base_reg     <= '0;
            pp_exponent_reg <= '0;
            error_reg       <= 1'b0;
            wdog_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        b_lat_reg      <= boundary;
                        idx_reg        <= '0;
                        pair_count_reg <= '0;
                        error_reg      <= 1'b0;
                        if (boundary >= BOUND_W'(2)) begin
                            ef_base_reg <= {1'b0, PRIME_TABLE[0]};
                        end
                    end
                end
                CLEAR: begin
                    wdog_reg <= '0;
                end
                RUN: begin
                    wdog_reg <= wdog_reg + WDOG_W'(1);
                    if (ef_ready) begin
                        pp_base_reg     <= {1'b0, prime_cur};
                        pp_exponent_reg <= ef_exponent;
                    end else if (wdog_expired) begin
                        error_reg <= 1'b1;
                    end
                end
                EMIT: begin
                    if (pp_ready) begin
                        pair_count_reg <= pair_count_reg + IDX_W'(1);
                        if (!last_pair) begin
                            idx_reg     <= idx_reg + IDX_W'(1);
                            ef_base_reg <= {1'b0, prime_next};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign error       = error_reg;
    assign pair_count  = pair_count_reg;
    assign ef_base     = ef_base_reg;
    assign ef_boundary = b_lat_reg;
    assign pp_base     = pp_base_reg;
    assign pp_exponent = pp_exponent_reg;

endmodule
